pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage load/hold/flush control, redirect and multi-cycle EX tracking.
// Optional stall watchdog built only when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl #(
   parameter int WDOG_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ready,
   input  logic        id_load_use,
   input  logic        ex_redirect,
   input  logic [63:0] ex_target,
   input  logic        ex_multi_start,
   input  logic [5:0]  ex_multi_lat,
   input  logic        mem_busy,
   output logic [1:0]  ctrl_pc,
   output logic [1:0]  ctrl_if_id,
   output logic [1:0]  ctrl_id_ex,
   output logic [1:0]  ctrl_ex_mem,
   output logic [1:0]  ctrl_mem_wb,
   output logic        pc_redirect,
   output logic [63:0] pc_target,
   output logic        wdog_err
);

   // state    | meaning
   // ST_RUN   | no multi-cycle op outstanding (cnt_q == 0)
   // ST_MULTI | multi-cycle op still occupying EX (cnt_q != 0)
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_MULTI = 1'b1
   } state_e;

   localparam logic [1:0] C_D = 2'b00;
   localparam logic [1:0] C_S = 2'b01;
   localparam logic [1:0] C_F = 2'b10;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        kill_q, kill_d;
   logic        start_acc;
   logic        ex_busy;
   logic        redirect_win;
   logic [1:0]  if_id_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= 6'd0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
      end
   end

   // A start is only accepted with EX free; lat 0/1 never occupies EX beyond its own cycle.
   always_comb begin
      start_acc = ex_multi_start && (cnt_q == 6'd0) && (ex_multi_lat >= 6'd2);
      ex_busy   = start_acc || (cnt_q != 6'd0);
      cnt_d     = cnt_q;
      state_d   = state_q;
      if (start_acc) begin
         cnt_d = ex_multi_lat - 6'd2;
      end else if (cnt_q != 6'd0) begin
         cnt_d = cnt_q - 6'd1;
      end
      case (state_q)
         ST_RUN:   if (start_acc && (ex_multi_lat >= 6'd3)) state_d = ST_MULTI;
         ST_MULTI: if (cnt_d == 6'd0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ctrl_pc      = C_D;
      if_id_raw    = C_D;
      ctrl_id_ex   = C_D;
      ctrl_ex_mem  = C_D;
      ctrl_mem_wb  = C_D;
      redirect_win = 1'b0;
      if (rst) begin
         ctrl_pc     = C_F;
         if_id_raw   = C_F;
         ctrl_id_ex  = C_F;
         ctrl_ex_mem = C_F;
         ctrl_mem_wb = C_F;
      end else if (mem_busy) begin
         ctrl_pc     = C_S;
         if_id_raw   = C_S;
         ctrl_id_ex  = C_S;
         ctrl_ex_mem = C_S;
         ctrl_mem_wb = C_F;
      end else if (ex_busy) begin
         ctrl_pc     = C_S;
         if_id_raw   = C_S;
         ctrl_id_ex  = C_S;
         ctrl_ex_mem = C_F;
      end else if (ex_redirect) begin
         if_id_raw    = C_F;
         ctrl_id_ex   = C_F;
         redirect_win = 1'b1;
      end else if (id_load_use) begin
         ctrl_pc    = C_S;
         if_id_raw  = C_S;
         ctrl_id_ex = C_F;
      end else if (!if_ready) begin
         ctrl_pc   = C_S;
         if_id_raw = C_F;
      end
      // The wrong-path fetch after a redirect must not enter ID.
      ctrl_if_id = (kill_q && (if_id_raw == C_D)) ? C_F : if_id_raw;
      pc_redirect = redirect_win;
      pc_target   = redirect_win ? ex_target : 64'd0;
      if (redirect_win) begin
         kill_d = 1'b1;
      end else if (ctrl_if_id != C_S) begin
         kill_d = 1'b0;
      end else begin
         kill_d = kill_q;
      end
   end

`ifdef PIPE_CTRL_WDOG_EN
   localparam int         WD_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   // Count saturates at the limit so the flag cannot be missed by wrap-around.
   always_comb begin
      wd_d = '0;
      if (ctrl_pc == C_S) begin
         wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
      end
      err_d = err_q || (wd_d == WD_MAX);
   end

   assign wdog_err = err_q && !rst;
`else
   // Limit only matters when the watchdog is built; keep it referenced.
   if (WDOG_LIMIT < 0) begin : g_limit_unused
   end

   assign wdog_err = 1'b0;
`endif

endmodule
